// File: rtl/ask_pkg.sv
// Shared definitions for the 4-ASK symbol source.
//   - Gray symbol type and the four 1s17 amplitude levels
//   - PRBS15 register width and feedback tap positions
//   - map_level(): Gray symbol -> signed 1s17 level
package ask_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 13;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        GRAY_M3 = 2'b00,
        GRAY_M1 = 2'b01,
        GRAY_P1 = 2'b11,
        GRAY_P3 = 2'b10
    } gray_sym_e;

    localparam logic signed [17:0] LVL_M3 = -18'sd98304;  // -0.75
    localparam logic signed [17:0] LVL_M1 = -18'sd32768;  // -0.25
    localparam logic signed [17:0] LVL_P1 =  18'sd32768;  // +0.25
    localparam logic signed [17:0] LVL_P3 =  18'sd98304;  // +0.75

    function automatic logic signed [17:0] map_level(input gray_sym_e sym);
        logic signed [17:0] lvl;
        case (sym)
            GRAY_M3: lvl = LVL_M3;
            GRAY_M1: lvl = LVL_M1;
            GRAY_P1: lvl = LVL_P1;
            GRAY_P3: lvl = LVL_P3;
            default: lvl = 18'sd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/prbs15_gen.sv
// PRBS15 generator, x^15+x^14+1 Fibonacci form, two bits per step.
//   clk    : clock
//   reset  : synchronous active-low reset, loads SEED
//   step_i : advance the register by two shifts
//   sym_o  : the two bits the next step produces, first bit in the MSB
module prbs15_gen
    import ask_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_i,
    output logic [1:0] sym_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] lfsr_mid_s;
    logic              nb1_s;
    logic              nb2_s;

    // Two look-ahead shifts; sym_o shows the bits before they are committed.
    always_comb begin
        nb1_s      = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
        lfsr_mid_s = {lfsr_q[LFSR_W-2:0], nb1_s};
        nb2_s      = lfsr_mid_s[TAP_A] ^ lfsr_mid_s[TAP_B];
        sym_o      = {nb1_s, nb2_s};
        if (step_i) begin
            lfsr_d = {lfsr_mid_s[LFSR_W-2:0], nb2_s};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ask4_symbol_src.sv
// 4-ASK symbol source with upsampling, feeding a TX pulse-shaping filter.
//   clk, reset (sync active-low), en (one output sample per enabled cycle)
//   src_sel   : 0 internal PRBS, 1 external symbols via sym_in/sym_valid/sym_ready
//   mode_hold : 0 zero-stuff, 1 sample-and-hold between symbols
//   x_out     : signed 1s17 sample, registered, holds while en=0
//   sym_strobe: marks the x_out sample carrying a new symbol
//   underrun  : sticky, an external symbol slot found sym_valid=0
module ask4_symbol_src
    import ask_pkg::*;
#(
    parameter int                SPS       = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               src_sel,
    input  logic               mode_hold,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] x_out,
    output logic               sym_strobe,
    output logic               underrun
);

    localparam int PW = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [LFSR_W-1:0] SEED_EFF =
        (LFSR_SEED == 15'd0) ? LFSR_DEFAULT_SEED : LFSR_SEED;

    logic [PW-1:0]      phase_q, phase_d;
    logic signed [17:0] x_q, x_d;
    logic signed [17:0] hold_q, hold_d;
    logic               strobe_q, strobe_d;
    logic               under_q, under_d;
    logic               slot_s;
    logic               prbs_step_s;
    logic [1:0]         prbs_sym_s;
    logic signed [17:0] level_s;

    assign slot_s      = en & (phase_q == {PW{1'b0}});
    assign prbs_step_s = slot_s & ~src_sel & reset;
    assign sym_ready   = slot_s & src_sel & reset;

    prbs15_gen #(
        .SEED (SEED_EFF)
    ) u_prbs (
        .clk    (clk),
        .reset  (reset),
        .step_i (prbs_step_s),
        .sym_o  (prbs_sym_s)
    );

    // Symbol level for the current slot; a missing external symbol maps to 0.
    always_comb begin
        level_s = 18'sd0;
        if (!src_sel) begin
            level_s = map_level(gray_sym_e'(prbs_sym_s));
        end else if (sym_valid) begin
            level_s = map_level(gray_sym_e'(sym_in));
        end else begin
            level_s = 18'sd0;
        end
    end

    // Phase counter, upsampler and underrun next-state.
    always_comb begin
        phase_d  = phase_q;
        x_d      = x_q;
        hold_d   = hold_q;
        strobe_d = 1'b0;
        under_d  = under_q;
        if (en) begin
            if (phase_q == PW'(SPS - 1)) begin
                phase_d = {PW{1'b0}};
            end else begin
                phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (slot_s) begin
                x_d      = level_s;
                hold_d   = level_s;
                strobe_d = 1'b1;
                if (src_sel && !sym_valid) begin
                    under_d = 1'b1;
                end else begin
                    under_d = under_q;
                end
            end else if (mode_hold) begin
                x_d = hold_q;
            end else begin
                x_d = 18'sd0;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q  <= {PW{1'b0}};
            x_q      <= 18'sd0;
            hold_q   <= 18'sd0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            x_q      <= x_d;
            hold_q   <= hold_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
        end
    end

    assign x_out      = x_q;
    assign sym_strobe = strobe_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_ask4_symbol_src.sv
// Randomized scoreboard bench for ask4_symbol_src (default parameters).
module tb_ask4_symbol_src;

    localparam int SPS = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               src_sel;
    logic               mode_hold;
    logic [1:0]         sym_in;
    logic               sym_valid;
    logic               sym_ready;
    logic signed [17:0] x_out;
    logic               sym_strobe;
    logic               underrun;

    ask4_symbol_src #(.SPS(SPS), .LFSR_SEED(15'h7FFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .src_sel    (src_sel),
        .mode_hold  (mode_hold),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .x_out      (x_out),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   x;
        logic chk_st;
        logic st;
        logic un;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state
    int   prbs_bits[4096];
    int   m_ptr;
    int   m_phase;
    int   m_hold;
    int   m_last_x;
    logic m_under;

    function automatic int gray_level(input int s);
        case (s)
            0: return -98304;
            1: return -32768;
            3: return 32768;
            2: return 98304;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr    = 15;
        m_phase  = 0;
        m_hold   = 0;
        m_last_x = 0;
        m_under  = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Drive one cycle of inputs, check sym_ready, advance the model.
    task automatic drive(input logic r, input logic e, input logic s, input logic h,
                         input logic [1:0] sy, input logic v);
        exp_t ex;
        int   lvl;
        @(negedge clk);
        reset = r; en = e; src_sel = s; mode_hold = h; sym_in = sy; sym_valid = v;
        #1;
        check("sym_ready", int'(sym_ready), int'(r && e && s && (m_phase == 0)));
        if (!r) begin
            model_reset();
        end else begin
            ex.chk_st = e;
            ex.st     = 1'b0;
            if (e) begin
                if (m_phase == 0) begin
                    if (!s) begin
                        lvl = gray_level(prbs_bits[m_ptr] * 2 + prbs_bits[m_ptr + 1]);
                        m_ptr += 2;
                    end else if (v) begin
                        lvl = gray_level(int'(sy));
                    end else begin
                        lvl = 0;
                        m_under = 1'b1;
                    end
                    m_hold   = lvl;
                    m_last_x = lvl;
                    ex.st    = 1'b1;
                end else begin
                    m_last_x = h ? m_hold : 0;
                end
                m_phase = (m_phase + 1) % SPS;
            end
            ex.x  = m_last_x;
            ex.un = m_under;
            q.push_back(ex);
        end
    endtask

    // Monitor: every non-reset edge yields one sample to compare.
    initial begin
        logic r_s;
        exp_t ex;
        forever begin
            @(posedge clk);
            r_s = reset;
            #1;
            if (r_s === 1'b0) begin
                check("reset_x", int'(x_out), 0);
                check("reset_strobe", int'(sym_strobe), 0);
                check("reset_underrun", int'(underrun), 0);
            end else if (r_s === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
                end else begin
                    ex = q.pop_front();
                    check("x_out", int'(x_out), ex.x);
                    if (x_out > 18'sd98304 || x_out < -18'sd98304) begin
                        check("x_range", int'(x_out), ex.x);
                    end
                    if (ex.chk_st) check("sym_strobe", int'(sym_strobe), int'(ex.st));
                    check("underrun", int'(underrun), int'(ex.un));
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] tbl[6];
        tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11;
        tbl[3] = 2'b10; tbl[4] = 2'b10; tbl[5] = 2'b01;

        // PRBS bit stream: seed bits oldest-first, then b[n] = b[n-15] ^ b[n-14]
        for (int i = 0; i < 15; i++) prbs_bits[i] = 1;
        for (int i = 15; i < 4096; i++) prbs_bits[i] = prbs_bits[i-15] ^ prbs_bits[i-14];

        model_reset();
        reset = 1'b0; en = 1'b0; src_sel = 1'b0; mode_hold = 1'b0;
        sym_in = 2'b00; sym_valid = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // PRBS zero-stuff from seed
        repeat (40) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // reset at phase 2, then PRBS restarts from seed
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // en toggling
        for (int i = 0; i < 16; i++) drive(1'b1, 1'(i % 2 == 0), 1'b0, 1'b1, 2'b00, 1'b0);

        // external symbols, zero-stuff then hold, one missing slot
        for (int k = 0; k < 6; k++)
            for (int p = 0; p < SPS; p++)
                drive(1'b1, 1'b1, 1'b1, 1'(k >= 3), tbl[k], 1'b1);
        for (int p = 0; p < SPS; p++) drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
        repeat (8) drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // randomized mix
        for (int i = 0; i < 2500; i++) begin
            drive(1'(($urandom % 200) != 0), 1'(($urandom % 4) != 0),
                  1'($urandom % 2), 1'($urandom % 2),
                  2'($urandom % 4), 1'(($urandom % 8) != 0));
        end

        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ask4_symbol_src.md
ASK4_SYMBOL_SRC -- requirements
Module: ask4_symbol_src

Interface
REQ-001 SHALL have parameter SPS, default 4, samples per symbol (legal 2..16).
REQ-002 SHALL have parameter LFSR_SEED, default 15'h7FFF, PRBS reset state; value 0 is replaced by 15'h7FFF.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  sample enable, one output sample per cycle with en=1.
REQ-006 SHALL have port src_sel  input  1  0 = internal PRBS, 1 = external symbols.
REQ-007 SHALL have port mode_hold  input  1  0 = zero-stuff, 1 = sample-and-hold upsampling.
REQ-008 SHALL have port sym_in  input  2  external Gray symbol.
REQ-009 SHALL have port sym_valid  input  1  sym_in valid.
REQ-010 SHALL have port sym_ready  output  1  external symbol accepted this cycle when sym_valid=1.
REQ-011 SHALL have port x_out  output  18  signed 1s17 sample, feeds TX pulse-shaping filter x_in.
REQ-012 SHALL have port sym_strobe  output  1  marks x_out sample carrying a new symbol.
REQ-013 SHALL have port underrun  output  1  sticky, external source missed a symbol slot.

Function
REQ-014 SHALL keep phase counter 0..SPS-1, incremented on en, wrapping SPS-1 -> 0; frozen when en=0.
REQ-015 SHALL define a symbol slot as a cycle with en=1 and phase=0.
REQ-016 SHALL, in PRBS mode, per slot step a 15-bit Fibonacci LFSR twice (x^15+x^14+1: nb = s[14]^s[13], s <= {s[13:0],nb}); first generated bit is symbol MSB.
REQ-017 SHALL advance the LFSR only in slots with src_sel=0.
REQ-018 SHALL drive sym_ready = en & (phase==0) & src_sel, combinationally; transfer when sym_ready & sym_valid.
REQ-019 SHALL, on slot with src_sel=1 and sym_valid=0, use level 0, set underrun, and still advance phase.
REQ-020 SHALL map Gray symbols: 00 -> -98304 (-0.75), 01 -> -32768 (-0.25), 11 -> +32768 (+0.25), 10 -> +98304 (+0.75).
REQ-021 SHALL register x_out one cycle after the enabled cycle (latency 1); x_out holds when en=0.
REQ-022 SHALL output mapped level at phase 0; at phases 1..SPS-1 output 0 (mode_hold=0) or the last level (mode_hold=1).
REQ-023 SHALL pulse sym_strobe for exactly the x_out sample from phase 0, aligned with x_out.
REQ-024 SHALL sample src_sel and mode_hold every cycle; changes take effect at the next enabled cycle, no glitch on x_out beyond the new rule.
REQ-025 SHALL never produce x_out outside [-98304, +98304].

Reset
REQ-026 SHALL, with reset=0 at posedge, set phase=0, LFSR=LFSR_SEED (or 15'h7FFF), x_out=0, held level=0, sym_strobe=0, underrun=0.
REQ-027 SHALL hold sym_ready=0 while reset=0; reset mid-symbol aborts the symbol and restarts at phase 0 on first en after release.
REQ-028 SHALL clear underrun only by reset.

Structure
REQ-029 SHALL place level constants (four 1s17 values), Gray symbol typedef, LFSR width and tap positions in a shared package ask_pkg.
REQ-030 SHALL implement the LFSR as sub-module prbs15_gen (2-bit per step output, step enable, seed).
REQ-031 SHALL have mapper and upsampler in the top module, no other sub-modules.

Verification
REQ-032 Reset release, en=1, src_sel=0, mode_hold=0, default seed -> first 7 symbols -98304, each followed by 3 zeros, sym_strobe every 4th sample.
REQ-033 src_sel=1, sym_valid=1, sym_in sequence 00,01,11,10 -> x_out -98304,-32768,+32768,+98304 at phase 0, one-cycle latency after each sym_ready.
REQ-034 src_sel=1, sym_valid=0 for one slot -> that symbol's samples all 0, underrun=1 and stays 1 until reset.
REQ-035 mode_hold=1, sym_in=10 then 01 -> four samples +98304 then four samples -32768.
REQ-036 en toggling 1,0,1,0 -> phase and x_out frozen on en=0 cycles; LFSR steps only in slots.
REQ-037 reset asserted at phase 2 -> x_out=0, phase restarts, PRBS sequence repeats from seed (first symbol -98304).
